// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default modulus/width, stage FSM states, modular helpers.
// Optional output halving in intt_sdf_stage is enabled by INTT_SCALE_EN.
package ntt_pkg;

  localparam int unsigned NTT_W = 32;
  localparam int unsigned NTT_Q = 7681;
  // Primitive root of NTT_Q used to derive the twiddle tables.
  localparam longint unsigned NTT_GEN = 64'd17;

  typedef logic [NTT_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } state_t;

  function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] q);
    logic [63:0] s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction

  function automatic logic [63:0] mod_sub(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] q);
    return (a >= b) ? a - b : a + q - b;
  endfunction

  function automatic logic [63:0] mod_half(input logic [63:0] x, input logic [63:0] q);
    return x[0] ? ((x + q) >> 1) : (x >> 1);
  endfunction

  // gen^((q-1)/(2*delay)) has order 2*delay and serves as the inverse twiddle step.
  function automatic logic [63:0] tw_inv(input int unsigned k, input int unsigned delay,
                                         input longint unsigned q, input longint unsigned gen);
    longint unsigned e;
    longint unsigned base;
    longint unsigned r;
    e    = longint'(k) * ((q - 64'd1) / (64'd2 * longint'(delay)));
    base = gen % q;
    r    = 64'd1;
    while (e != 64'd0) begin
      if (e[0]) r = (r * base) % q;
      base = (base * base) % q;
      e    = e >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply: full 2W-bit product reduced mod Q.
// Zero latency; no flow control.
module mod_mul #(
  parameter int unsigned W = 32,
  parameter int unsigned Q = 7681
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  logic [2*W-1:0] prod;

  assign prod = (2*W)'(a) * (2*W)'(b);
  assign p    = W'(prod % (2*W)'(Q));

endmodule

// File: rtl/intt_sdf_stage.sv
// Radix-2 Gentleman-Sande inverse-NTT SDF stage; registered output, 1-cycle latency,
// in_ready drops only while draining feedback. Optional x/2 output scaling: INTT_SCALE_EN.
module intt_sdf_stage
  import ntt_pkg::*;
#(
  parameter int unsigned W     = NTT_W,
  parameter int unsigned Q     = NTT_Q,
  parameter int unsigned DELAY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         err
);

  localparam int CW  = (DELAY > 1) ? $clog2(2 * DELAY) : 1;
  localparam int DCW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] LAST_PH = CW'(2 * DELAY - 1);
  localparam logic [CW-1:0] A_END   = CW'(DELAY - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [DCW-1:0]  drain_cnt;
  logic [W-1:0]    dl_dat [DELAY];
  logic [DELAY-1:0] dl_tag;

  logic            accept;
  logic            phase_b;
  logic [W-1:0]    head_dat;
  logic            head_tag;
  logic [W-1:0]    sum_dat;
  logic [W-1:0]    diff_dat;
  logic [W-1:0]    fb_dat;
  logic [W-1:0]    tw_rom [2*DELAY];

  logic            shift;
  logic            emit;
  logic [W-1:0]    emit_dat;
  logic [W-1:0]    out_val;
  logic [W-1:0]    push_dat;
  logic            push_tag;

  // Indexed directly by cnt; only the phase-B half is ever selected.
  for (genvar i = 0; i < 2 * DELAY; i++) begin : g_tw
    if (i >= DELAY) begin : g_b
      assign tw_rom[i] = W'(tw_inv(i - DELAY, DELAY, 64'(Q), NTT_GEN));
    end else begin : g_a
      assign tw_rom[i] = W'(1);
    end
  end

  assign in_ready = (state != DRAIN);
  assign accept   = in_valid && in_ready;
  assign phase_b  = (cnt >= CW'(DELAY));
  assign head_dat = dl_dat[DELAY-1];
  assign head_tag = dl_tag[DELAY-1];
  assign sum_dat  = W'(mod_add(64'(head_dat), 64'(in_data), 64'(Q)));
  assign diff_dat = W'(mod_sub(64'(head_dat), 64'(in_data), 64'(Q)));

  mod_mul #(.W(W), .Q(Q)) u_mul (
    .a (diff_dat),
    .b (tw_rom[cnt]),
    .p (fb_dat)
  );

`ifdef INTT_SCALE_EN
  assign out_val = W'(mod_half(64'(emit_dat), 64'(Q)));
`else
  assign out_val = emit_dat;
`endif

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    emit      = 1'b0;
    emit_dat  = head_dat;
    push_dat  = '0;
    push_tag  = 1'b0;
    if (state == DRAIN) begin
      shift = 1'b1;
      emit  = head_tag;
      if (drain_cnt == DCW'(DELAY - 1)) state_nxt = IDLE;
    end else if (accept) begin
      shift = 1'b1;
      if (phase_b) begin
        emit     = 1'b1;
        emit_dat = sum_dat;
        push_dat = fb_dat;
        push_tag = 1'b1;
      end else begin
        push_dat = in_data;
        // Feedback left from an earlier group is only trusted once running.
        emit     = (state == RUN) && head_tag;
      end
      if (state == IDLE) begin
        state_nxt = (cnt == A_END) ? RUN : FILL;
      end else if (state == FILL) begin
        if (cnt == A_END) state_nxt = RUN;
      end else if (in_last && cnt == LAST_PH) begin
        state_nxt = DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      dl_tag    <= '0;
      for (int i = 0; i < DELAY; i++) dl_dat[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (shift) begin
        for (int i = DELAY - 1; i > 0; i--) begin
          dl_dat[i] <= dl_dat[i-1];
          dl_tag[i] <= dl_tag[i-1];
        end
        dl_dat[0] <= push_dat;
        dl_tag[0] <= push_tag;
      end
      if (accept) cnt <= (cnt == LAST_PH) ? '0 : cnt + CW'(1);
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DCW'(1);
        if (state_nxt == IDLE) begin
          drain_cnt <= '0;
          cnt       <= '0;
          dl_tag    <= '0;
        end
      end
      if (accept && in_last && cnt != LAST_PH) err <= 1'b1;
      out_valid <= emit;
      if (emit) out_data <= out_val;
    end
  end

endmodule

// File: tb/tb_intt_sdf_stage.sv
// Scoreboard bench for intt_sdf_stage (DELAY=2, Q=7681); expected outputs queued at issue.
module tb_intt_sdf_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic [31:0] out_data;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  intt_sdf_stage #(.W(32), .Q(7681), .DELAY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .err       (err)
  );

  function automatic int sc(input int x);
`ifdef INTT_SCALE_EN
    return (x % 2 != 0) ? (x + 7681) / 2 : x / 2;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    exp_q.push_back(sc(a));
    exp_q.push_back(sc(b));
    exp_q.push_back(sc(c));
    exp_q.push_back(sc(d));
  endtask

  task automatic send(input int d, input bit last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
  endtask

  // n gap cycles; out_valid must be low in each cycle following a gap cycle.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) chk("gap_out_valid", int'(out_valid), 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain_check(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_ready_d0"}, int'(in_ready), 0);
    @(negedge clk);
    chk({tag, "_ready_d1"}, int'(in_ready), 0);
    @(negedge clk);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %0d, expected no output", out_data);
        end else begin
          chk("out_data", int'(out_data), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;

    // Single group with drain.
    push4(4, 6, 7679, 915);
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    drain_check("single");

    // Two groups: first group's feedback leaves during samples 5 and 6.
    push4(4, 6, 7679, 915);
    push4(12, 14, 7679, 915);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    send(5, 0); send(6, 0); send(7, 0); send(8, 1);
    drain_check("two_grp");

    // Gaps freeze the pipeline: between samples 2/3 and between 5/6.
    push4(4, 6, 7679, 915);
    push4(12, 14, 7679, 915);
    send(1, 0); send(2, 0);
    gap(3);
    send(3, 0); send(4, 0); send(5, 0);
    gap(3);
    send(6, 0); send(7, 0); send(8, 1);
    drain_check("gaps");
    chk("err_clean", int'(err), 0);

    // Misplaced in_last: sticky err, no drain, stream continues.
    push4(4, 6, 7679, 915);
    send(1, 0); send(2, 1); send(3, 0);
    chk("err_set", int'(err), 1);
    chk("no_drain_ready", int'(in_ready), 1);
    send(4, 1);
    drain_check("err_run");
    chk("err_sticky", int'(err), 1);

    // Reset after the first drained output discards the rest.
    exp_q.push_back(sc(4));
    exp_q.push_back(sc(6));
    exp_q.push_back(sc(7679));
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drain_valid", int'(out_valid), 0);
    chk("rst_drain_ready", int'(in_ready), 1);
    chk("rst_drain_err", int'(err), 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
